seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive-side counterpart of the clock's 8-digit multiplexed 7-seg driver.
//  Samples the scanned digit-select/segment bus and rebuilds the displayed
//  frame as hour/min/sec BCD.
//  Used as an on-board loopback checker and as the bench monitor for the display path.
// PARAMETERS
//  STABLE_CYC   16         cycles select+segments must hold unchanged before capture
//  TIMEOUT_CYC  2_500_000  cycles with no capture before a forced (stale) frame publish
// PORTS
//  clk          in   1   system clock, 100 MHz
//  rst          in   1   reset, asynchronous, active-high
//  seg_which    in   8   digit select, one-hot; bit7 = digit0 (leftmost) .. bit0 = digit7
//  seg_data     in   8   segment code; bit7 = a .. bit1 = g, bit0 = dp
//  hour_bcd     out  8   {digit0, digit1} of last published frame
//  min_bcd      out  8   {digit3, digit4}
//  sec_bcd      out  8   {digit6, digit7}
//  blank_mask   out  8   1 = digit not captured in last frame (same bit order as seg_which)
//  frame_valid  out  1   one-cycle pulse: new frame published
//  format_ok    out  1   last frame well-formed (rules below)
//  stale        out  1   last publish was caused by timeout
// BEHAVIOUR
//  Reset: all outputs 0 except blank_mask = 8'hFF. Internal digit store = 4'hF,
//   seen-mask = 0, prev_idx = 0, counters = 0. Reset aborts any partial frame.
//  Stability filter:
//   - counter clears when {seg_which, seg_data} differs from the previous cycle.
//   - otherwise it increments, saturating at STABLE_CYC.
//   - capture fires once, on the cycle the count reaches STABLE_CYC, if seg_which is exactly one-hot.
//   - seg_which = 0 (blanked slot) or multi-hot never captures; multi-hot is ignored silently.
//  Segment decode (dp ignored):
//   - 0..9 = FC,60,DA,F2,66,B6,BE,E0,FE,F6 (dp masked to 0).
//   - '-' (02) -> 4'hA; any other pattern -> 4'hE (invalid).
//  Capture at index i (0..7):
//   - if seen-mask is nonzero and i <= prev_idx: frame boundary. First publish the
//     current store/mask, then start a new frame containing only digit i.
//   - else: store digit i, set seen bit i.
//   - prev_idx <= i in both cases.
//  Publish (registered):
//   - frame_valid = 1 for exactly one cycle, the cycle after the boundary capture.
//   - BCD/mask/format_ok/stale update on that same cycle and hold until the next publish.
//   - blank digits appear in the BCD outputs as 4'hF.
//  Timeout:
//   - a 22-bit idle counter clears on every capture.
//   - when it reaches TIMEOUT_CYC with seen-mask nonzero: publish with stale = 1, clear seen-mask.
//   - when seen-mask = 0: the counter saturates and nothing is published.
//  format_ok = 1 iff all of the following hold:
//   - no blank digits.
//   - digits 2 and 5 = 4'hA.
//   - all other digits are 0..9.
//   - hour <= 23, min <= 59, sec <= 59.
//  Simultaneous events:
//   - boundary capture and timeout in the same cycle: the boundary wins,
//     stale = 0, idle counter cleared.
//   - the publish for the old frame and the store of the new first digit occur together.
//  Latency: display change -> frame_valid <= one scan frame + STABLE_CYC + 2 cycles.
// CONFIGURATION
//  SEG_SCAN_STATS_EN defined:
//   - adds output err_cnt [15:0]: count of published frames with format_ok = 0,
//     saturating at 16'hFFFF, cleared by rst.
//   - adds output frame_cnt [15:0]: total publishes, wrapping.
//  SEG_SCAN_STATS_EN undefined:
//   - neither port nor its logic exists.
//   - all other behaviour is identical.
// TESTING (STABLE_CYC = 4, TIMEOUT_CYC = 1000 in bench)
//  1. Scan "23-59-58" twice, 50 cycles per digit, slots 0..7
//     -> one frame_valid after slot0 of pass 2; hour_bcd = 23, min_bcd = 59, sec_bcd = 58,
//        blank_mask = 00, format_ok = 1, stale = 0.
//  2. Same scan, seg_which = 0 for slots 0 and 1 (blink)
//     -> blank_mask = 80|40 = C0, hour_bcd = FF, format_ok = 0.
//  3. Hold each slot only 3 cycles
//     -> no capture, no frame_valid; after 1000 idle cycles still no publish (mask empty).
//  4. Scan slots 0..4 of "12-34-56", then freeze seg_which = 0
//     -> after 1000 cycles frame_valid; stale = 1, blank_mask = 07, min_bcd = 34.
//  5. Slot 4 data = 8'h9C (invalid) in "10-00-00"
//     -> min_bcd = 0E, format_ok = 0; err_cnt = 1 when SEG_SCAN_STATS_EN is defined.
//  6. Assert rst mid-frame after slot 3
//     -> outputs return to reset values immediately; next complete scan publishes
//        only post-reset digits.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Rebuilds the hour/min/sec BCD frame from a scanned 8-digit 7-segment bus.
// Optional SEG_SCAN_STATS_EN adds err_cnt / frame_cnt publish statistics.
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_which,
  input  logic [7:0]  seg_data,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  min_bcd,
  output logic [7:0]  sec_bcd,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        format_ok,
  output logic        stale
`ifdef SEG_SCAN_STATS_EN
  ,
  output logic [15:0] err_cnt,
  output logic [15:0] frame_cnt
`endif
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);
  localparam logic [21:0]   IDLE_MAX = 22'(TIMEOUT_CYC);

  function automatic logic [3:0] seg_decode(input logic [7:0] code);
    logic [3:0] v;
    case (code & 8'hFE)
      8'hFC:   v = 4'h0;
      8'h60:   v = 4'h1;
      8'hDA:   v = 4'h2;
      8'hF2:   v = 4'h3;
      8'h66:   v = 4'h4;
      8'hB6:   v = 4'h5;
      8'hBE:   v = 4'h6;
      8'hE0:   v = 4'h7;
      8'hFE:   v = 4'h8;
      8'hF6:   v = 4'h9;
      8'h02:   v = 4'hA;
      default: v = 4'hE;
    endcase
    return v;
  endfunction

  // seg_which bit7 is digit 0, so the digit index is the mirrored bit position
  function automatic logic [2:0] sel_index(input logic [7:0] w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++)
      if (w[k]) idx = 3'(7 - k);
    return idx;
  endfunction

  function automatic logic frame_ok(input logic [31:0] f, input logic [7:0] blank);
    logic [3:0] d [8];
    logic       ok;
    for (int k = 0; k < 8; k++) d[k] = f[31-4*k -: 4];
    ok = (blank == 8'h00) && (d[2] == 4'hA) && (d[5] == 4'hA);
    for (int k = 0; k < 8; k++)
      if (k != 2 && k != 5 && d[k] > 4'd9) ok = 1'b0;
    ok = ok && ((d[0] < 4'd2) || (d[0] == 4'd2 && d[1] <= 4'd3))
            && (d[3] <= 4'd5) && (d[6] <= 4'd5);
    return ok;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: bus history, stability filter, digit store, idle timer
  logic [15:0]   bus_p0;
  logic [SW-1:0] stab_cnt_p0;
  logic [21:0]   idle_p0;
  logic [3:0]    dig_p0 [8];
  logic [7:0]    seen_p0;
  logic [2:0]    prev_idx_p0;

  logic          bus_chg;
  logic [SW-1:0] stab_nxt;
  logic          cap_vld;
  logic [2:0]    cap_idx;
  logic [3:0]    cap_code;
  logic [7:0]    cap_bit;
  logic          seen_any;
  logic          boundary;
  logic          timeout;
  logic          publish;
  logic [31:0]   pub_frame;
  logic          pub_ok;

  always_comb begin
    bus_chg  = ({seg_which, seg_data} != bus_p0);
    stab_nxt = bus_chg ? '0 : ((stab_cnt_p0 == STAB_MAX) ? STAB_MAX : stab_cnt_p0 + 1'b1);
    cap_vld  = !bus_chg && (stab_cnt_p0 == STAB_MAX - 1'b1) && $onehot(seg_which);
    cap_idx  = sel_index(seg_which);
    cap_code = seg_decode(seg_data);
    cap_bit  = 8'h80 >> cap_idx;
    seen_any = |seen_p0;
    boundary = cap_vld && seen_any && (cap_idx <= prev_idx_p0);
    // a capture restarts the idle timer, so it always pre-empts the timeout
    timeout  = !cap_vld && seen_any && (idle_p0 == IDLE_MAX);
    publish  = boundary || timeout;
    pub_frame = '0;
    for (int k = 0; k < 8; k++)
      pub_frame[31-4*k -: 4] = seen_p0[7-k] ? dig_p0[k] : 4'hF;
    pub_ok = frame_ok(pub_frame, ~seen_p0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_p0      <= '0;
      stab_cnt_p0 <= '0;
      idle_p0     <= '0;
      seen_p0     <= '0;
      prev_idx_p0 <= '0;
      for (int k = 0; k < 8; k++) dig_p0[k] <= 4'hF;
    end else begin
      bus_p0      <= {seg_which, seg_data};
      stab_cnt_p0 <= stab_nxt;
      if (cap_vld) begin
        idle_p0     <= '0;
        prev_idx_p0 <= cap_idx;
        if (boundary) begin
          for (int k = 0; k < 8; k++) dig_p0[k] <= 4'hF;
          seen_p0 <= cap_bit;
        end else begin
          seen_p0 <= seen_p0 | cap_bit;
        end
        dig_p0[cap_idx] <= cap_code;
      end else begin
        if (idle_p0 != IDLE_MAX) idle_p0 <= idle_p0 + 22'd1;
        if (timeout) seen_p0 <= '0;
      end
    end
  end

  // Stage p1: registered publish
  logic vld_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      hour_bcd   <= '0;
      min_bcd    <= '0;
      sec_bcd    <= '0;
      blank_mask <= 8'hFF;
      format_ok  <= 1'b0;
      stale      <= 1'b0;
    end else begin
      vld_p1 <= publish;
      if (publish) begin
        hour_bcd   <= pub_frame[31:24];
        min_bcd    <= pub_frame[19:12];
        sec_bcd    <= pub_frame[7:0];
        blank_mask <= ~seen_p0;
        format_ok  <= pub_ok;
        stale      <= timeout;
      end
    end
  end

  assign frame_valid = vld_p1;

`ifdef SEG_SCAN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else if (publish) begin
      frame_cnt <= frame_cnt + 16'd1;
      if (!pub_ok) err_cnt <= sat_inc16(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: cycle model plus directed scans.
module tb_seg_scan_decoder;
  localparam int STABLE = 4;
  localparam int TMO    = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg_which = 8'h00;
  logic [7:0] seg_data  = 8'h00;
  logic [7:0] hour_bcd, min_bcd, sec_bcd, blank_mask;
  logic       frame_valid, format_ok, stale;
`ifdef SEG_SCAN_STATS_EN
  logic [15:0] err_cnt, frame_cnt;
`endif

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .seg_which(seg_which), .seg_data(seg_data),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .blank_mask(blank_mask), .frame_valid(frame_valid),
    .format_ok(format_ok), .stale(stale)
`ifdef SEG_SCAN_STATS_EN
    , .err_cnt(err_cnt), .frame_cnt(frame_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // Model: run length of identical bus values, per-digit store and seen flags
  logic [7:0]  codes [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
  logic [15:0] m_last;
  int          m_run, m_prev, m_idle;
  logic [3:0]  m_dig [8];
  logic        m_seen [8];
  logic [7:0]  e_hour, e_min, e_sec, e_blank;
  logic        e_fv, e_fok, e_stale;
  logic [15:0] e_err, e_frm;

  task automatic m_reset();
    m_last = 16'h0000; m_run = 1; m_prev = 0; m_idle = 0;
    for (int k = 0; k < 8; k++) begin m_dig[k] = 4'hF; m_seen[k] = 1'b0; end
    e_hour = 0; e_min = 0; e_sec = 0; e_blank = 8'hFF;
    e_fv = 0; e_fok = 0; e_stale = 0; e_err = 0; e_frm = 0;
  endtask

  function automatic logic [3:0] m_decode(input logic [7:0] c);
    logic [7:0] m;
    m = c & 8'hFE;
    for (int v = 0; v < 10; v++) if (m == codes[v]) return 4'(v);
    if (m == 8'h02) return 4'hA;
    return 4'hE;
  endfunction

  task automatic m_publish(input logic st);
    logic [3:0] v [8];
    int h, mi, s;
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      v[k] = m_seen[k] ? m_dig[k] : 4'hF;
      if (!m_seen[k]) ok = 1'b0;
      e_blank[7-k] = !m_seen[k];
      if (k != 2 && k != 5 && v[k] > 9) ok = 1'b0;
    end
    if (v[2] != 4'hA || v[5] != 4'hA) ok = 1'b0;
    h = v[0] * 10 + v[1]; mi = v[3] * 10 + v[4]; s = v[6] * 10 + v[7];
    if (h > 23 || mi > 59 || s > 59) ok = 1'b0;
    e_hour = {v[0], v[1]}; e_min = {v[3], v[4]}; e_sec = {v[6], v[7]};
    e_fok = ok; e_stale = st; e_fv = 1'b1;
    e_frm = e_frm + 16'd1;
    if (!ok && e_err != 16'hFFFF) e_err = e_err + 16'd1;
  endtask

  task automatic m_step();
    logic [15:0] bus;
    int ones, idx;
    logic cap, any;
    bus = {seg_which, seg_data};
    e_fv = 1'b0;
    cap = 1'b0;
    if (bus != m_last) m_run = 1;
    else if (m_run < STABLE + 1) begin
      m_run++;
      if (m_run == STABLE + 1) cap = 1'b1;
    end
    m_last = bus;
    ones = 0; idx = 0;
    for (int k = 0; k < 8; k++) if (seg_which[7-k]) begin ones++; idx = k; end
    if (ones != 1) cap = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 8; k++) any = any | m_seen[k];
    if (cap) begin
      if (any && idx <= m_prev) begin
        m_publish(1'b0);
        for (int k = 0; k < 8; k++) begin m_seen[k] = 1'b0; m_dig[k] = 4'hF; end
      end
      m_dig[idx] = m_decode(seg_data);
      m_seen[idx] = 1'b1;
      m_prev = idx;
      m_idle = 0;
    end else if (m_idle == TMO && any) begin
      m_publish(1'b1);
      for (int k = 0; k < 8; k++) m_seen[k] = 1'b0;
    end else if (m_idle < TMO) begin
      m_idle++;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if ({hour_bcd, min_bcd, sec_bcd, blank_mask, frame_valid, format_ok, stale} !==
          {e_hour, e_min, e_sec, e_blank, e_fv, e_fok, e_stale}) begin
        failures++;
        if (failures <= 20)
          $display("FAIL cycle_outputs t=%0t got h=%h m=%h s=%h bl=%h fv=%b ok=%b st=%b exp h=%h m=%h s=%h bl=%h fv=%b ok=%b st=%b",
                   $time, hour_bcd, min_bcd, sec_bcd, blank_mask, frame_valid, format_ok, stale,
                   e_hour, e_min, e_sec, e_blank, e_fv, e_fok, e_stale);
      end
`ifdef SEG_SCAN_STATS_EN
      checks++;
      if ({err_cnt, frame_cnt} !== {e_err, e_frm}) begin
        failures++;
        if (failures <= 20)
          $display("FAIL cycle_stats t=%0t got err=%0d frm=%0d exp err=%0d frm=%0d",
                   $time, err_cnt, frame_cnt, e_err, e_frm);
      end
`endif
      if (frame_valid === 1'b1) pulses++;
    end
  end

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive_slot(input int slot, input logic [7:0] code, input logic blank, input int hold);
    @(negedge clk);
    seg_which = blank ? 8'h00 : 8'(8'h80 >> slot);
    seg_data  = code;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] c [8], input int first, input int last,
                      input logic [7:0] bmask, input int hold);
    for (int s = first; s <= last; s++) drive_slot(s, c[s], bmask[s], hold);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    seg_which = 8'h00; seg_data = 8'h00;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; seg_which = 8'h00; seg_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] f1 [8] = '{8'hDA, 8'hF2, 8'h02, 8'hB6, 8'hF6, 8'h02, 8'hB6, 8'hFE};
  logic [7:0] f4 [8] = '{8'h60, 8'hDA, 8'h02, 8'hF2, 8'h66, 8'h02, 8'hB6, 8'hBE};
  logic [7:0] f5 [8] = '{8'h60, 8'hFC, 8'h02, 8'hFC, 8'h9C, 8'h02, 8'hFC, 8'hFC};

  initial begin
    do_reset();
    check_val("reset_blank", blank_mask, 8'hFF);
    check_val("reset_hour", hour_bcd, 8'h00);
    check_val("reset_fv", frame_valid, 0);

    // 1: full well-formed scan, twice
    pulses = 0;
    scan(f1, 0, 7, 8'h00, 50);
    scan(f1, 0, 7, 8'h00, 50);
    check_val("t1_pulses", pulses, 1);
    check_val("t1_hour", hour_bcd, 8'h23);
    check_val("t1_min", min_bcd, 8'h59);
    check_val("t1_sec", sec_bcd, 8'h58);
    check_val("t1_blank", blank_mask, 8'h00);
    check_val("t1_ok", format_ok, 1);
    check_val("t1_stale", stale, 0);

    // 2: slots 0 and 1 blanked
    pulses = 0;
    scan(f1, 0, 7, 8'h03, 50);
    scan(f1, 0, 7, 8'h03, 50);
    check_val("t2_pulses", pulses, 2);
    check_val("t2_blank", blank_mask, 8'hC0);
    check_val("t2_hour", hour_bcd, 8'hFF);
    check_val("t2_min", min_bcd, 8'h59);
    check_val("t2_ok", format_ok, 0);

    // 3: slots too short to capture, then long idle with empty mask
    do_reset();
    pulses = 0;
    scan(f1, 0, 7, 8'h00, 3);
    scan(f1, 0, 7, 8'h00, 3);
    idle(1100);
    check_val("t3_pulses", pulses, 0);
    check_val("t3_blank", blank_mask, 8'hFF);

    // 4: partial frame then freeze -> stale publish
    pulses = 0;
    scan(f4, 0, 4, 8'h00, 50);
    idle(1100);
    check_val("t4_pulses", pulses, 1);
    check_val("t4_stale", stale, 1);
    check_val("t4_blank", blank_mask, 8'h07);
    check_val("t4_min", min_bcd, 8'h34);
    check_val("t4_hour", hour_bcd, 8'h12);

    // 5: invalid segment pattern in slot 4
    do_reset();
    pulses = 0;
    scan(f5, 0, 7, 8'h00, 50);
    scan(f5, 0, 0, 8'h00, 50);
    check_val("t5_pulses", pulses, 1);
    check_val("t5_min", min_bcd, 8'h0E);
    check_val("t5_hour", hour_bcd, 8'h10);
    check_val("t5_ok", format_ok, 0);
`ifdef SEG_SCAN_STATS_EN
    check_val("t5_err_cnt", err_cnt, 1);
    check_val("t5_frame_cnt", frame_cnt, 1);
`endif

    // 6: reset mid-frame
    scan(f4, 0, 3, 8'h00, 50);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t6_rst_blank", blank_mask, 8'hFF);
    check_val("t6_rst_hour", hour_bcd, 8'h00);
    check_val("t6_rst_ok", format_ok, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    scan(f4, 4, 7, 8'h00, 50);
    scan(f4, 0, 0, 8'h00, 50);
    check_val("t6_pulses", pulses, 1);
    check_val("t6_blank", blank_mask, 8'hF0);
    check_val("t6_hour", hour_bcd, 8'hFF);
    check_val("t6_min", min_bcd, 8'hF4);
    check_val("t6_sec", sec_bcd, 8'h56);

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
